// File: rtl/commit_trace_pkg.sv
// commit_trace_pkg: trace record type, record/writeback kinds and field widths
// Shared by the commit trace buffer, its FIFO and its bus interface.
package commit_trace_pkg;
    localparam int PC_W    = 64;
    localparam int INSN_W  = 32;
    localparam int REG_W   = 5;
    localparam int DATA_W  = 64;
    localparam int CAUSE_W = 64;

    typedef enum logic {KIND_COMMIT = 1'b0, KIND_TRAP = 1'b1} kind_e;
    typedef enum logic [1:0] {WB_NONE = 2'd0, WB_XPR = 2'd1, WB_FPR = 2'd2} wb_kind_e;

    typedef struct packed {
        kind_e               kind;
        logic [PC_W-1:0]     pc;
        logic [INSN_W-1:0]   insn;
        wb_kind_e            wb_kind;
        logic [REG_W-1:0]    waddr;
        logic [DATA_W-1:0]   wdata;
        logic [CAUSE_W-1:0]  cause;
    } trace_rec_t;
endpackage

// File: rtl/commit_trace_buffer_if.sv
// commit_trace_buffer_if: commit-side inputs, checker-side record stream and status flags
// slave  : the trace buffer (consumes retire events, produces records and flags)
// master : the environment (core commit stage plus co-simulation checker)
interface commit_trace_buffer_if import commit_trace_pkg::*; #(parameter int COMMITS = 2) ();
    logic [COMMITS-1:0]              in_valid;
    logic [COMMITS-1:0][PC_W-1:0]    in_pc;
    logic [COMMITS-1:0][INSN_W-1:0]  in_insn;
    logic [COMMITS-1:0][1:0]         in_wb_kind;
    logic [COMMITS-1:0][REG_W-1:0]   in_waddr;
    logic [COMMITS-1:0][DATA_W-1:0]  in_wdata;
    logic                            trap_valid;
    logic [CAUSE_W-1:0]              trap_cause;
    logic                            in_ready;
    logic                            out_valid;
    logic                            out_ready;
    logic                            out_kind;
    logic [PC_W-1:0]                 out_pc;
    logic [INSN_W-1:0]               out_insn;
    logic [1:0]                      out_wb_kind;
    logic [REG_W-1:0]                out_waddr;
    logic [DATA_W-1:0]               out_wdata;
    logic [CAUSE_W-1:0]              out_cause;
    logic [63:0]                     commit_count;
    logic                            overflow;
    logic                            hang;

    modport slave (
        input  in_valid, in_pc, in_insn, in_wb_kind, in_waddr, in_wdata, trap_valid, trap_cause, out_ready,
        output in_ready, out_valid, out_kind, out_pc, out_insn, out_wb_kind, out_waddr, out_wdata, out_cause,
        output commit_count, overflow, hang
    );
    modport master (
        output in_valid, in_pc, in_insn, in_wb_kind, in_waddr, in_wdata, trap_valid, trap_cause, out_ready,
        input  in_ready, out_valid, out_kind, out_pc, out_insn, out_wb_kind, out_waddr, out_wdata, out_cause,
        input  commit_count, overflow, hang
    );
endinterface

// File: rtl/commit_trace_fifo.sv
// commit_trace_fifo: circular FIFO taking up to PORTS compacted records per cycle, one out
// clock/reset : clock, synchronous active-low reset
// wr_n/wr_data: number of records written this cycle, taken from wr_data[0..wr_n-1]
// rd_en       : pop head; rd_data is the head record (all zero when empty); count is occupancy
module commit_trace_fifo import commit_trace_pkg::*; #(
    parameter int PORTS = 3,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int NW = $clog2(PORTS + 1)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NW-1:0]          wr_n,
    input  trace_rec_t [PORTS-1:0] wr_data,
    input  logic                   rd_en,
    output trace_rec_t             rd_data,
    output logic [AW:0]            count
);
    trace_rec_t mem [DEPTH];
    logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;

    assign wptr_d  = wptr_q + (AW+1)'(wr_n);
    assign rptr_d  = rptr_q + (AW+1)'(rd_en);
    assign count   = wptr_q - rptr_q;
    assign rd_data = (count != '0) ? mem[rptr_q[AW-1:0]] : '0;

    always_ff @(posedge clock) begin
        if (!reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < PORTS; i++)
            if (i < int'(wr_n)) mem[wptr_q[AW-1:0] + AW'(i)] <= wr_data[i];
    end
endmodule

// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer: serialises per-cycle commit/trap events into one trace record per cycle
// clock/reset : clock, synchronous active-low reset
// bus (slave) : retire slots + trap in, in_ready backpressure, head record out with
//               out_valid/out_ready, commit_count, sticky overflow and hang flags
module commit_trace_buffer import commit_trace_pkg::*; #(
    parameter int COMMITS = 2,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 100000
) (
    input  logic                 clock,
    input  logic                 reset,
    commit_trace_buffer_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int NW = $clog2(COMMITS + 2);
    localparam int WW = $clog2(TIMEOUT + 1);

    trace_rec_t [COMMITS:0] wr_rec;
    trace_rec_t             head;
    logic [NW-1:0]          n_pres;
    logic [CW-1:0]          count;
    logic                   in_ready, deq;
    logic [63:0]            commit_count_q;
    logic                   overflow_q, hang_q;
    logic [WW-1:0]          wd_q, wd_d;

    // Pack valid slots (oldest first) then the trap into consecutive write ports.
    always_comb begin
        wr_rec = '0;
        n_pres = '0;
        for (int i = 0; i < COMMITS; i++)
            if (bus.in_valid[i]) begin
                wr_rec[n_pres] = '{kind: KIND_COMMIT, pc: bus.in_pc[i], insn: bus.in_insn[i],
                                   wb_kind: wb_kind_e'(bus.in_wb_kind[i]), waddr: bus.in_waddr[i],
                                   wdata: bus.in_wdata[i], cause: '0};
                n_pres = n_pres + NW'(1);
            end
        if (bus.trap_valid) begin
            wr_rec[n_pres] = '{kind: KIND_TRAP, pc: '0, insn: '0, wb_kind: WB_NONE, waddr: '0,
                               wdata: '0, cause: bus.trap_cause};
            n_pres = n_pres + NW'(1);
        end
    end

    // Registered occupancy only: room for a worst-case cycle of COMMITS+1 records.
    assign in_ready = count <= CW'(DEPTH - COMMITS - 1);
    assign deq      = (count != '0) && bus.out_ready;
    assign wd_d     = (in_ready && |bus.in_valid) ? '0 :
                      (wd_q == WW'(TIMEOUT)) ? wd_q : wd_q + WW'(1);

    commit_trace_fifo #(.PORTS(COMMITS + 1), .DEPTH(DEPTH)) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .wr_n    (in_ready ? n_pres : '0),
        .wr_data (wr_rec),
        .rd_en   (deq),
        .rd_data (head),
        .count   (count)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            commit_count_q <= '0;
            overflow_q     <= 1'b0;
            hang_q         <= 1'b0;
            wd_q           <= '0;
        end else begin
            commit_count_q <= commit_count_q + 64'(deq && head.kind == KIND_COMMIT);
            overflow_q     <= overflow_q | ((n_pres != '0) && !in_ready);
            hang_q         <= hang_q | (wd_d == WW'(TIMEOUT));
            wd_q           <= wd_d;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = count != '0;
    assign bus.out_kind     = head.kind;
    assign bus.out_pc       = head.pc;
    assign bus.out_insn     = head.insn;
    assign bus.out_wb_kind  = head.wb_kind;
    assign bus.out_waddr    = head.waddr;
    assign bus.out_wdata    = head.wdata;
    assign bus.out_cause    = head.cause;
    assign bus.commit_count = commit_count_q;
    assign bus.overflow     = overflow_q;
    assign bus.hang         = hang_q;
endmodule

// File: tb/tb_commit_trace_buffer.sv
// tb_commit_trace_buffer: directed table, corner sequences and random traffic vs a queue model
module tb_commit_trace_buffer;
    localparam int COMMITS = 2;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 16;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    commit_trace_buffer_if #(.COMMITS(COMMITS)) bus ();
    commit_trace_buffer #(.COMMITS(COMMITS), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit          kind;
        logic [63:0] pc;
        logic [31:0] insn;
        logic [1:0]  wb;
        logic [4:0]  waddr;
        logic [63:0] wdata;
        logic [63:0] cause;
    } rec_t;

    typedef struct {
        logic [1:0]  v;
        logic [63:0] pc0, pc1;
        logic        tv;
        logic [63:0] cause;
        logic        ordy;
        logic        e_valid, e_kind;
        logic [63:0] e_pc, e_cause, e_cc;
        logic        e_rdy, e_ovf;
    } vec_t;

    rec_t        q[$];
    logic [63:0] m_cc;
    bit          m_ovf, m_hang;
    int          m_idle;
    int          total = 0;
    int          bad = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    task automatic drive(input logic [1:0] v, input logic [63:0] pc0, input logic [63:0] pc1,
                         input logic tv, input logic [63:0] cause, input logic ordy);
        bus.in_valid   = v;
        bus.in_pc      = {pc1, pc0};
        bus.in_insn    = {32'h00100093, 32'h00000013};
        bus.in_wb_kind = {2'd2, 2'd1};
        bus.in_waddr   = {5'd7, 5'd3};
        bus.in_wdata   = {pc1 ^ 64'h55, pc0 + 64'd1};
        bus.trap_valid = tv;
        bus.trap_cause = cause;
        bus.out_ready  = ordy;
    endtask

    // One clock: advance the reference model on the edge, then compare every output.
    task automatic step();
        rec_t r;
        bit   rdy, deq, acc;
        int   n;
        rdy = (DEPTH - q.size()) >= COMMITS + 1;
        deq = q.size() != 0 && bus.out_ready;
        @(posedge clock);
        if (!reset) begin
            q.delete();
            m_cc = 0; m_ovf = 0; m_hang = 0; m_idle = 0;
        end else begin
            if (deq) begin
                if (q[0].kind == 1'b0) m_cc++;
                void'(q.pop_front());
            end
            n = $countones(bus.in_valid) + int'(bus.trap_valid);
            acc = 0;
            if (n > 0 && !rdy) m_ovf = 1;
            else begin
                for (int s = 0; s < COMMITS; s++)
                    if (bus.in_valid[s]) begin
                        r = '{1'b0, bus.in_pc[s], bus.in_insn[s], bus.in_wb_kind[s],
                              bus.in_waddr[s], bus.in_wdata[s], 64'd0};
                        q.push_back(r);
                        acc = 1;
                    end
                if (bus.trap_valid) begin
                    r = '{1'b1, 64'd0, 32'd0, 2'd0, 5'd0, 64'd0, bus.trap_cause};
                    q.push_back(r);
                end
            end
            m_idle = acc ? 0 : (m_idle < TIMEOUT ? m_idle + 1 : m_idle);
            if (m_idle >= TIMEOUT) m_hang = 1;
        end
        #1;
        if (q.size() == 0) r = '{1'b0, 64'd0, 32'd0, 2'd0, 5'd0, 64'd0, 64'd0};
        else r = q[0];
        chk("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
        chk("out_kind", 64'(bus.out_kind), 64'(r.kind));
        chk("out_pc", bus.out_pc, r.pc);
        chk("out_insn", 64'(bus.out_insn), 64'(r.insn));
        chk("out_wb_kind", 64'(bus.out_wb_kind), 64'(r.wb));
        chk("out_waddr", 64'(bus.out_waddr), 64'(r.waddr));
        chk("out_wdata", bus.out_wdata, r.wdata);
        chk("out_cause", bus.out_cause, r.cause);
        chk("commit_count", bus.commit_count, m_cc);
        chk("in_ready", 64'(bus.in_ready), 64'((DEPTH - q.size()) >= COMMITS + 1));
        chk("overflow", 64'(bus.overflow), 64'(m_ovf));
        chk("hang", 64'(bus.hang), 64'(m_hang));
    endtask

    task automatic do_reset();
        drive(2'b00, 0, 0, 0, 0, 0);
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    vec_t tbl[14];

    initial begin
        tbl[0]  = '{2'b01, 64'h80000000, 0, 0, 0, 0, 1, 0, 64'h80000000, 0, 0, 1, 0};
        tbl[1]  = '{2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0};
        tbl[2]  = '{2'b10, 0, 64'h80000004, 1, 2, 0, 1, 0, 64'h80000004, 0, 1, 1, 0};
        tbl[3]  = '{2'b00, 0, 0, 0, 0, 1, 1, 1, 0, 2, 2, 1, 0};
        tbl[4]  = '{2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2, 1, 0};
        tbl[5]  = '{2'b11, 64'h100, 64'h104, 1, 3, 0, 1, 0, 64'h100, 0, 2, 1, 0};
        tbl[6]  = '{2'b11, 64'h200, 64'h204, 1, 3, 0, 1, 0, 64'h100, 0, 2, 0, 0};
        tbl[7]  = '{2'b01, 64'h300, 0, 0, 0, 0, 1, 0, 64'h100, 0, 2, 0, 1};
        tbl[8]  = '{2'b00, 0, 0, 0, 0, 1, 1, 0, 64'h104, 0, 3, 1, 1};
        tbl[9]  = '{2'b00, 0, 0, 0, 0, 1, 1, 1, 0, 3, 4, 1, 1};
        tbl[10] = '{2'b00, 0, 0, 0, 0, 1, 1, 0, 64'h200, 0, 4, 1, 1};
        tbl[11] = '{2'b00, 0, 0, 0, 0, 1, 1, 0, 64'h204, 0, 5, 1, 1};
        tbl[12] = '{2'b00, 0, 0, 0, 0, 1, 1, 1, 0, 3, 6, 1, 1};
        tbl[13] = '{2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 0, 6, 1, 1};

        do_reset();
        chk("reset out_valid", 64'(bus.out_valid), 0);
        chk("reset in_ready", 64'(bus.in_ready), 1);
        chk("reset out_pc", bus.out_pc, 0);

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].v, tbl[i].pc0, tbl[i].pc1, tbl[i].tv, tbl[i].cause, tbl[i].ordy);
            step();
            chk($sformatf("tbl%0d valid", i), 64'(bus.out_valid), 64'(tbl[i].e_valid));
            chk($sformatf("tbl%0d kind", i), 64'(bus.out_kind), 64'(tbl[i].e_kind));
            chk($sformatf("tbl%0d pc", i), bus.out_pc, tbl[i].e_pc);
            chk($sformatf("tbl%0d cause", i), bus.out_cause, tbl[i].e_cause);
            chk($sformatf("tbl%0d cc", i), bus.commit_count, tbl[i].e_cc);
            chk($sformatf("tbl%0d rdy", i), 64'(bus.in_ready), 64'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d ovf", i), 64'(bus.overflow), 64'(tbl[i].e_ovf));
        end

        drive(2'b11, 64'h400, 64'h404, 1, 5, 0);
        step();
        drive(2'b11, 64'h500, 64'h504, 0, 0, 0);
        step();
        chk("five buffered", 64'(q.size()), 5);
        drive(2'b00, 0, 0, 0, 0, 0);
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("flush out_valid", 64'(bus.out_valid), 0);
        chk("flush commit_count", bus.commit_count, 0);
        chk("flush overflow", 64'(bus.overflow), 0);

        drive(2'b00, 0, 0, 0, 0, 1);
        for (int i = 0; i < TIMEOUT - 1; i++) step();
        chk("hang before timeout", 64'(bus.hang), 0);
        step();
        chk("hang at timeout", 64'(bus.hang), 1);
        drive(2'b01, 64'h600, 0, 0, 0, 1);
        step();
        step();
        chk("hang sticky", 64'(bus.hang), 1);

        do_reset();
        for (int i = 0; i < 3 * DEPTH; i++) begin
            drive(2'b01, 64'h1000 + 64'(4 * i), 0, 0, 0, 1);
            step();
            chk($sformatf("wrap%0d pc", i), bus.out_pc, 64'h1000 + 64'(4 * i));
            chk($sformatf("wrap%0d rdy", i), 64'(bus.in_ready), 1);
        end

        do_reset();
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(299) != 0);
            drive(2'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                  ($urandom_range(3) == 0), {$urandom, $urandom}, ($urandom_range(3) != 0));
            bus.in_wb_kind = {2'($urandom_range(2)), 2'($urandom_range(2))};
            bus.in_waddr   = 10'($urandom);
            bus.in_insn    = {$urandom, $urandom};
            if (i % 500 >= 460) bus.in_valid = 2'b00;
            step();
        end
        reset = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
